// File: rtl/rank_filter_pkg.sv
// Shared constants and FSM encoding for the masked rank-order filter slice.
package rank_filter_pkg;

  localparam int N           = 31;
  localparam int ADDR_BITS   = 8;
  localparam int NUM_SAMPLES = 255;
  // Sample value loaded into window slots that have not yet seen real input.
  localparam logic [7:0] NO_INPUT = 8'h00;
  localparam int RANK_DEFAULT = N / 2 + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/valid_index_delay.sv
// Depth-D shift register carrying a {valid, index} tuple; index is zeroed when not valid.
module valid_index_delay #(
  parameter int unsigned D = 1,
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_index,
  output logic         out_valid,
  output logic [W-1:0] out_index
);

  logic [D-1:0] v;
  logic [W-1:0] idx [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int unsigned i = 0; i < D; i++) idx[i] <= '0;
    end else begin
      v[0]   <= in_valid;
      idx[0] <= in_valid ? in_index : '0;
      for (int unsigned i = 1; i < D; i++) begin
        v[i]   <= v[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end

  assign out_valid = v[D-1];
  assign out_index = idx[D-1];

endmodule

// File: rtl/rank_filter_sequencer.sv
// Run sequencer for the rank-order filter: ROM fetch, filter enable, RAM write-back,
// plus the free-running display readback address.
module rank_filter_sequencer #(
  parameter int N           = rank_filter_pkg::N,
  parameter int ADDR_BITS   = rank_filter_pkg::ADDR_BITS,
  parameter int NUM_SAMPLES = rank_filter_pkg::NUM_SAMPLES,
  parameter int ROM_LAT     = 1,
  parameter int FILT_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 step_up,
  input  logic                 step_down,
  output logic [ADDR_BITS-1:0] rom_addr,
  output logic                 filt_clr,
  output logic                 filt_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic                 busy,
  output logic                 done
);

  import rank_filter_pkg::*;

  // One spare bit keeps NUM_SAMPLES = 2**ADDR_BITS representable.
  localparam int CNT_W = ADDR_BITS + 1;
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_SAMPLES - 1);

  seq_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 issue_valid;
  logic                 rom_v;
  logic [ADDR_BITS-1:0] rom_idx;

  assign issue_valid = (state == ST_FETCH);

  valid_index_delay #(.D(ROM_LAT), .W(ADDR_BITS)) u_rom_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue_valid),
    .in_index  (rom_addr),
    .out_valid (rom_v),
    .out_index (rom_idx)
  );

  valid_index_delay #(.D(FILT_LAT), .W(ADDR_BITS)) u_filt_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rom_v),
    .in_index  (rom_idx),
    .out_valid (ram_we),
    .out_index (ram_waddr)
  );

  assign filt_en = rom_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rom_addr <= '0;
      filt_clr <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            rom_addr <= '0;
            filt_clr <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state    <= ST_FETCH;
          filt_clr <= 1'b0;
        end
        ST_FETCH: begin
          if (cnt == LAST_CNT) begin
            state <= ST_DRAIN;
          end else begin
            cnt      <= cnt + 1'b1;
            rom_addr <= ADDR_BITS'(cnt + 1'b1);
          end
        end
        ST_DRAIN: begin
          // The last tuple leaving the delay line is the final RAM write.
          if (ram_we && ram_waddr == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
    end else if (step_up && !step_down) begin
      rd_addr <= rd_addr + 1'b1;
    end else if (step_down && !step_up) begin
      rd_addr <= rd_addr - 1'b1;
    end
  end

endmodule

// File: doc/rank_filter_sequencer.md
# rank_filter_sequencer

Sequencer for the masked rank-order filter datapath. It replaces the gated `run_clk` scheme with a single free-running clock plus enables, and manages one processing run from start to finish:

- issues sample addresses to the synchronous input ROM;
- presents each returned sample to the filter with a one-cycle enable;
- writes each filter result into the output RAM at the matching index.

It also owns the display readback address that the up/down buttons step through.

## Interface

Parameters:

- `N`, 31: filter window length; forwarded for the package constant only.
- `ADDR_BITS`, 8: width of ROM/RAM/readback addresses.
- `NUM_SAMPLES`, 255: samples per run; range 1..2^ADDR_BITS.
- `ROM_LAT`, 1: cycles from `rom_addr` to valid ROM data; must be ≥1.
- `FILT_LAT`, 1: cycles from `filt_en` to valid filter output; must be ≥1.

Ports:

- `clk`, in, 1: single system clock; all state on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- `step_up`, in, 1: debounced single-cycle pulse; increments `rd_addr`.
- `step_down`, in, 1: debounced single-cycle pulse; decrements `rd_addr`.
- `rom_addr`, out, ADDR_BITS: ROM read address.
- `filt_clr`, out, 1: clears the filter window; high for exactly one cycle per run.
- `filt_en`, out, 1: ROM data is a valid new sample; the filter shifts it in.
- `ram_we`, out, 1: RAM write enable for the filter output.
- `ram_waddr`, out, ADDR_BITS: RAM write address.
- `rd_addr`, out, ADDR_BITS: RAM read address for the seven-segment display.
- `busy`, out, 1: a run is in progress.
- `done`, out, 1: the last run has completed; held until the next `start` or `rst`.

## Operation

- FSM states and transitions:
  - IDLE → CLEAR on `start`.
  - CLEAR → FETCH unconditionally, after one cycle.
  - FETCH → DRAIN after the issue counter reaches NUM_SAMPLES-1.
  - DRAIN → DONE once the last write has occurred.
  - DONE → CLEAR on `start`.
- CLEAR:
  - `filt_clr`=1 and `busy`=1.
  - Issue counter and `rom_addr` are set to 0.
- FETCH:
  - `rom_addr` = issue index c, for c = 0..NUM_SAMPLES-1, one new address per cycle.
  - Each issue pushes the tuple (valid, c) into the delay line.
- Delay line:
  - A valid arriving after ROM_LAT cycles drives `filt_en`.
  - The same tuple, delayed a further FILT_LAT cycles, drives `ram_we` with `ram_waddr`=c.
  - Result: RAM address c always holds the filter output produced by the ROM sample at address c.
- DRAIN: no new issues; `rom_addr` holds NUM_SAMPLES-1; the delay line empties.
- DONE: `busy`=0, `done`=1; all enables are 0.
- `start` while `busy`=1 is ignored. Concurrent `start` and `rst`: reset wins.
- Readback counter:
  - Independent of the FSM and always active.
  - Wraps modulo 2^ADDR_BITS in both directions.
  - `step_up` and `step_down` in the same cycle: no change.
- Address arithmetic is unsigned, ADDR_BITS wide. The issue counter is sized so that NUM_SAMPLES = 2^ADDR_BITS does not overflow before FETCH exits.

## Timing

- Reset values:
  - All outputs 0; FSM in IDLE; delay line cleared.
  - Reset is asynchronous on assertion and takes effect immediately, mid-run included. No RAM write completes after `rst` rises.
- Cycle numbering: `start` is sampled at edge E0; cycle k means the cycle after edge E0+k.
- Cycle 0: CLEAR; `filt_clr`=1, `busy`=1.
- Cycles 1..NUM_SAMPLES: FETCH; `rom_addr` = k-1.
- `filt_en`: high in cycles 1+ROM_LAT .. NUM_SAMPLES+ROM_LAT, contiguous.
- `ram_we`: high in cycles 1+ROM_LAT+FILT_LAT .. NUM_SAMPLES+ROM_LAT+FILT_LAT, with `ram_waddr` = k-1-ROM_LAT-FILT_LAT.
- First DONE cycle is NUM_SAMPLES+ROM_LAT+FILT_LAT+1. `busy` falls and `done` rises on the same edge.
- A `start` in DONE clears `done` on the next edge, as the FSM enters CLEAR.
- Readback latency: `rd_addr` updates on the edge that samples the step pulse.

## Structure

- Shared package `rank_filter_pkg` holds:
  - FSM state encoding (IDLE, CLEAR, FETCH, DRAIN, DONE);
  - default constants N, ADDR_BITS, NUM_SAMPLES, NO_INPUT;
  - the `RANK_DEFAULT` = N/2+1 constant used by the top level.
- One sub-module, `valid_index_delay`: a parameterised shift register of depth D carrying {valid, index}. It is instantiated twice, with D=ROM_LAT and D=FILT_LAT.
- FSM and readback counter stay in `rank_filter_sequencer`.

## Test plan

- Reset: hold `rst` for 3 cycles with random inputs → every output 0; `start` during reset is ignored.
- Default parameters, `start` at E0:
  - `filt_clr` high in cycle 0 only;
  - `filt_en` high in cycles 2..256;
  - `ram_we` high in cycles 3..257, `ram_waddr` 0..254;
  - `done`=1 from cycle 258.
- NUM_SAMPLES=4, ROM_LAT=2, FILT_LAT=3, with a scoreboard ROM model (data = addr XOR 0x5A) and an identity filter model → RAM[0..3] = 0x5A,0x5B,0x58,0x59; exactly 4 writes.
- `start` pulsed at cycle 10 of a run → ignored; the run ends at the same cycle as an unperturbed run, with no second `filt_clr`.
- `rst` asserted at cycle 100, released, then `start` → no `ram_we` after the `rst` rise; the second run restarts at `ram_waddr` 0.
- Readback:
  - from 0, one `step_down` → 0xFF;
  - `step_up` and `step_down` together → unchanged;
  - 256 `step_up` pulses → back to 0xFF.
